arbiter_requester: RTL and testbench
====================================

ARBITER_REQUESTER -- requirements
Module: arbiter_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning bus data width in bits.
REQ-002 The block SHALL have parameter BURST_MAX, default 16, meaning the maximum beats per burst (power of two, at least 2).
REQ-003 The block SHALL have parameter REQ_TIMEOUT, default 64, meaning the grant-wait cycles before timeout is flagged.
REQ-004 i_clk  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_start_valid  in  1  a burst command is offered.
REQ-007 i_start_len  in  $clog2(BURST_MAX)  burst length minus one.
REQ-008 o_start_ready  out  1  the block accepts a command.
REQ-009 i_data_valid  in  1  a source beat is available.
REQ-010 i_data  in  DATA_W  source beat.
REQ-011 o_data_ready  out  1  the source beat is consumed this cycle.
REQ-012 o_req  out  1  request line to one round-robin arbiter port.
REQ-013 i_grant  in  1  grant bit for this port from the arbiter's registered grant vector.
REQ-014 o_bus_valid  out  1  bus beat valid.
REQ-015 o_bus_data  out  DATA_W  bus beat data.
REQ-016 o_bus_last  out  1  final beat of the burst.
REQ-017 i_bus_ready  in  1  bus accepts the beat.
REQ-018 o_burst_cnt  out  16  count of completed bursts, wrapping modulo 2^16.
REQ-019 o_timeout  out  1  sticky grant-timeout flag.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, XFER and RELEASE, held in a registered state variable.
REQ-021 In IDLE, o_start_ready SHALL be 1 and o_req SHALL be 0.
- Command handshake: i_start_valid and o_start_ready both high.
- On handshake, the block SHALL latch i_start_len, clear the beat counter and enter REQ.
REQ-022 o_req SHALL be 1 in REQ and XFER and 0 in IDLE and RELEASE; o_req SHALL be registered.
REQ-023 In REQ, the FSM SHALL move to XFER on the first cycle i_grant=1.
- A grant seen in IDLE or RELEASE SHALL be ignored.
REQ-024 A beat SHALL be transferred in a cycle exactly when the state is XFER, i_grant=1, i_data_valid=1 and i_bus_ready=1.
REQ-025 In XFER, the outputs SHALL be:
- o_bus_valid = i_grant AND i_data_valid.
- o_bus_data = i_data.
- o_data_ready = i_grant AND i_bus_ready.
- All other states: o_bus_valid=0 and o_data_ready=0.
REQ-026 o_bus_last SHALL be 1 in XFER when the beat counter equals the latched length; the counter SHALL increment on each transferred beat.
REQ-027 If i_grant drops in XFER, the block SHALL stall with no beats, keep o_req=1, hold the counter and resume when i_grant returns.
REQ-028 On the transferred beat with o_bus_last=1:
- The FSM SHALL enter RELEASE.
- o_burst_cnt SHALL increment by 1, wrapping from 0xFFFF to 0.
REQ-029 RELEASE SHALL last at least one cycle and until i_grant=0, then the FSM SHALL return to IDLE.
- This guarantees o_req low for at least one cycle between bursts, so the arbiter can rotate.
REQ-030 A command SHALL NOT be accepted outside IDLE, so back-to-back bursts are separated by at least one RELEASE cycle plus one IDLE cycle.
REQ-031 A length field of 0 SHALL mean a single beat, which carries o_bus_last=1.

Reset
REQ-032 While i_rst=1 at a clock edge:
- State SHALL become IDLE.
- The beat counter, latched length, o_burst_cnt and o_timeout SHALL become 0.
- o_req SHALL be 0 on the next cycle.
REQ-033 A reset during REQ or XFER SHALL abandon the burst without asserting o_bus_last; any untransferred beats are dropped.
REQ-034 During reset, o_start_ready, o_data_ready and o_bus_valid SHALL be 0.

Configuration
REQ-035 The macro ARB_REQ_TIMEOUT_EN SHALL select the timeout feature.
- Defined: a wait counter SHALL clear on entry to REQ and increment each REQ cycle without grant.
- Defined: when the counter reaches REQ_TIMEOUT, o_timeout SHALL be set and stay 1 until reset; the FSM SHALL keep requesting.
- Not defined: the counter SHALL be absent and o_timeout SHALL be tied to 0.

Verification
REQ-036 Reset then a command of len=3 with grant after 2 cycles and data/ready always high -> exactly 4 beats, last on beat 4, o_burst_cnt=1, o_req low for at least 1 cycle.
REQ-037 A len=7 burst with i_grant dropped for 3 cycles after beat 2 -> no beats during the gap, o_req stays 1, 8 beats total with o_bus_last only on beat 8.
REQ-038 A len=0 command -> one beat with o_bus_last=1, then RELEASE, then IDLE.
REQ-039 i_bus_ready toggling every cycle with len=3 -> beats only on ready cycles, i_data consumed once per beat, order preserved.
REQ-040 i_rst pulsed after beat 2 of len=5 -> next cycle state IDLE, o_req=0, o_burst_cnt=0, no o_bus_last seen.
REQ-041 With ARB_REQ_TIMEOUT_EN defined and REQ_TIMEOUT=64, grant withheld 70 cycles -> o_timeout=1 from cycle 64, burst completes after grant, flag stays set; without the macro -> o_timeout stays 0.

Source files
------------

// File: rtl/arbiter_requester.sv
// rtl/arbiter_requester.sv - burst requester for one round-robin arbiter port
// Optional grant-wait timeout: define ARB_REQ_TIMEOUT_EN to build the wait
// counter; without it o_timeout is tied low.
module arbiter_requester #(
   parameter int DATA_W      = 32,
   parameter int BURST_MAX   = 16,
   parameter int REQ_TIMEOUT = 64
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start_valid,
   input  logic [$clog2(BURST_MAX)-1:0] i_start_len,
   output logic                         o_start_ready,
   input  logic                         i_data_valid,
   input  logic [DATA_W-1:0]            i_data,
   output logic                         o_data_ready,
   output logic                         o_req,
   input  logic                         i_grant,
   output logic                         o_bus_valid,
   output logic [DATA_W-1:0]            o_bus_data,
   output logic                         o_bus_last,
   input  logic                         i_bus_ready,
   output logic [15:0]                  o_burst_cnt,
   output logic                         o_timeout
);

   localparam int LEN_W = $clog2(BURST_MAX);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_XFER    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat_cnt;
   logic             req_q;
   logic [15:0]      burst_cnt_q;

   logic             xfer_live;
   logic             is_last;
   logic             beat_fire;
   logic             start_fire;

   // Handshake outputs are combinational on the live bus signals but are
   // forced low while reset is applied so nothing moves during reset.
   always_comb begin
      xfer_live     = (state == ST_XFER) && !i_rst;
      is_last       = (beat_cnt == len_q);
      o_start_ready = (state == ST_IDLE) && !i_rst;
      o_bus_valid   = xfer_live && i_grant && i_data_valid;
      o_data_ready  = xfer_live && i_grant && i_bus_ready;
      o_bus_last    = xfer_live && is_last;
      o_bus_data    = i_data;
      beat_fire     = o_bus_valid && i_bus_ready;
      start_fire    = o_start_ready && i_start_valid;
   end

   assign o_req       = req_q;
   assign o_burst_cnt = burst_cnt_q;

   // Burst sequencing: request, stream beats while granted, then drop the
   // request for at least one cycle so the arbiter can rotate.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         len_q       <= '0;
         beat_cnt    <= '0;
         req_q       <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_fire) begin
                  len_q    <= i_start_len;
                  beat_cnt <= '0;
                  req_q    <= 1'b1;
                  state    <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (i_grant) begin
                  state <= ST_XFER;
               end
            end
            ST_XFER: begin
               // A dropped grant simply produces no beat_fire, so the
               // counter holds and the request stays up until it returns.
               if (beat_fire) begin
                  if (is_last) begin
                     req_q       <= 1'b0;
                     burst_cnt_q <= burst_cnt_q + 16'd1;
                     state       <= ST_RELEASE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_RELEASE: begin
               // Wait for the arbiter to withdraw the grant before a new
               // command may be taken.
               if (!i_grant) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(REQ_TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;

   // Count ungranted REQ cycles; the flag is sticky until reset and the
   // request is never withdrawn because of it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (start_fire) begin
         wait_cnt <= '0;
      end else if ((state == ST_REQ) && !i_grant &&
                   (wait_cnt != WAIT_W'(REQ_TIMEOUT))) begin
         wait_cnt <= wait_cnt + 1'b1;
         if (wait_cnt == WAIT_W'(REQ_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign o_timeout = timeout_q;
`else
   // No wait counter in this build; the comparison is constant false for any
   // usable timeout setting and keeps the parameter referenced.
   assign o_timeout = (REQ_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_arbiter_requester.sv
// tb/tb_arbiter_requester.sv - scoreboard bench for arbiter_requester
module tb_arbiter_requester;

   localparam int DW    = 32;
   localparam int BMAX  = 16;
   localparam int LEN_W = $clog2(BMAX);
`ifdef ARB_REQ_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_start_valid = 1'b0;
   logic [LEN_W-1:0] i_start_len = '0;
   logic             o_start_ready;
   logic             i_data_valid = 1'b0;
   logic [DW-1:0]    i_data = '0;
   logic             o_data_ready;
   logic             o_req;
   logic             i_grant = 1'b0;
   logic             o_bus_valid;
   logic [DW-1:0]    o_bus_data;
   logic             o_bus_last;
   logic             i_bus_ready = 1'b1;
   logic [15:0]      o_burst_cnt;
   logic             o_timeout;

   arbiter_requester #(.DATA_W(DW), .BURST_MAX(BMAX), .REQ_TIMEOUT(64)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_start_valid(i_start_valid), .i_start_len(i_start_len), .o_start_ready(o_start_ready),
      .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
      .o_req(o_req), .i_grant(i_grant),
      .o_bus_valid(o_bus_valid), .o_bus_data(o_bus_data), .o_bus_last(o_bus_last),
      .i_bus_ready(i_bus_ready), .o_burst_cnt(o_burst_cnt), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] src_q[$];

   int checks = 0;
   int passed = 0;

   logic grant_allow = 1'b0;
   logic force_grant = 1'b0;
   logic toggle_ready = 1'b0;

   logic        s_req, s_grant, s_timeout, s_start_ready;
   logic [15:0] s_burst_cnt;
   logic        hs_seen;
   int burst_beats, last_cnt, last_at, consumed_cnt, ready_err, req_low;

   task automatic cycle();
      logic hs;
      logic consumed;
      logic [LEN_W-1:0] hs_len;
      beat_t e;
      i_grant = force_grant | (grant_allow & o_req);
      if (toggle_ready) i_bus_ready = ~i_bus_ready;
      i_data_valid = (src_q.size() > 0);
      i_data = (src_q.size() > 0) ? src_q[0] : '0;
      @(negedge i_clk);
      s_req = o_req; s_grant = i_grant; s_timeout = o_timeout;
      s_start_ready = o_start_ready; s_burst_cnt = o_burst_cnt;
      hs = i_start_valid & o_start_ready;
      hs_len = i_start_len;
      consumed = o_data_ready & i_data_valid;
      if (consumed) consumed_cnt++;
      if (o_data_ready && !i_bus_ready) ready_err++;
      if (!o_req) req_low++;
      if (o_bus_valid && i_bus_ready) begin
         burst_beats++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL beat_unexpected data=%h last=%b, no beat expected", o_bus_data, o_bus_last);
         end else begin
            e = exp_q.pop_front();
            if (o_bus_data !== e.data || o_bus_last !== e.last)
               $display("FAIL beat_%0d data=%h last=%b, expected data=%h last=%b",
                        burst_beats, o_bus_data, o_bus_last, e.data, e.last);
            else
               passed++;
         end
         if (o_bus_last) begin
            last_cnt++;
            last_at = burst_beats;
            req_low = 0;
         end
      end
      @(posedge i_clk);
      #1;
      if (consumed) void'(src_q.pop_front());
      if (hs) begin
         i_start_valid = 1'b0;
         hs_seen = 1'b1;
         burst_beats = 0; last_cnt = 0; last_at = 0; consumed_cnt = 0; ready_err = 0;
         for (int k = 0; k <= int'(hs_len); k++) begin
            e.data = $urandom;
            e.last = (k == int'(hs_len));
            src_q.push_back(e.data);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic issue(input int len);
      int n = 0;
      i_start_valid = 1'b1;
      i_start_len = LEN_W'(len);
      hs_seen = 1'b0;
      while (!hs_seen && n < 40) begin
         cycle();
         n++;
      end
      if (!hs_seen) begin
         checks++;
         $display("FAIL issue_handshake len=%0d not accepted within 40 cycles", len);
         i_start_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      cycle();
      while (!(exp_q.size() == 0 && o_start_ready) && n < 300) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= 300) $display("FAIL %s_idle not reached, %0d beats left", name, exp_q.size());
      else passed++;
   endtask

   task automatic wait_beats(input int target);
      int n = 0;
      while (burst_beats < target && n < 100) begin
         cycle();
         n++;
      end
      checks++;
      if (burst_beats < target) $display("FAIL wait_beats got %0d, expected %0d", burst_beats, target);
      else passed++;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      else passed++;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      cycle();
      cycle();
      checks++;
      if (s_start_ready !== 1'b0) $display("FAIL reset_start_ready got=%b expected=0", s_start_ready);
      else passed++;
      i_rst = 1'b0;
      cycle();
      chk("reset_req", int'(s_req), 0);
      chk("reset_start_ready_after", int'(s_start_ready), 1);
      chk("reset_burst_cnt", int'(s_burst_cnt), 0);
      chk("reset_timeout", int'(s_timeout), 0);
      force_grant = 1'b1;
      req_low = 0;
      repeat (3) cycle();
      force_grant = 1'b0;
      chk("idle_grant_ignored_req_low", req_low, 3);
      chk("idle_grant_ignored_ready", int'(o_start_ready), 1);
   endtask

   task automatic test_basic();
      grant_allow = 1'b0;
      issue(3);
      cycle();
      cycle();
      chk("basic_no_beats_before_grant", burst_beats, 0);
      grant_allow = 1'b1;
      wait_idle("basic");
      chk("basic_beats", burst_beats, 4);
      chk("basic_last_at", last_at, 4);
      chk("basic_last_cnt", last_cnt, 1);
      chk("basic_burst_cnt", int'(o_burst_cnt), 1);
      checks++;
      if (req_low < 1) $display("FAIL basic_req_low got=%0d expected>=1", req_low);
      else passed++;
   endtask

   task automatic test_stall();
      int held;
      grant_allow = 1'b1;
      issue(7);
      wait_beats(2);
      grant_allow = 1'b0;
      held = burst_beats;
      for (int g = 0; g < 3; g++) begin
         cycle();
         chk($sformatf("stall_req_%0d", g), int'(s_req), 1);
      end
      chk("stall_no_beats", burst_beats, held);
      grant_allow = 1'b1;
      wait_idle("stall");
      chk("stall_beats", burst_beats, 8);
      chk("stall_last_at", last_at, 8);
      chk("stall_last_cnt", last_cnt, 1);
      chk("stall_burst_cnt", int'(o_burst_cnt), 2);
   endtask

   task automatic test_single();
      issue(0);
      wait_idle("single");
      chk("single_beats", burst_beats, 1);
      chk("single_last_at", last_at, 1);
      chk("single_burst_cnt", int'(o_burst_cnt), 3);
      checks++;
      if (req_low < 1) $display("FAIL single_release got req_low=%0d expected>=1", req_low);
      else passed++;
   endtask

   task automatic test_ready_toggle();
      toggle_ready = 1'b1;
      issue(3);
      wait_idle("toggle");
      toggle_ready = 1'b0;
      i_bus_ready = 1'b1;
      chk("toggle_beats", burst_beats, 4);
      chk("toggle_consumed", consumed_cnt, 4);
      chk("toggle_ready_err", ready_err, 0);
      chk("toggle_burst_cnt", int'(o_burst_cnt), 4);
   endtask

   task automatic test_reset_mid();
      issue(5);
      wait_beats(2);
      i_rst = 1'b1;
      cycle();
      i_rst = 1'b0;
      cycle();
      chk("rstmid_req", int'(s_req), 0);
      chk("rstmid_start_ready", int'(s_start_ready), 1);
      chk("rstmid_burst_cnt", int'(s_burst_cnt), 0);
      chk("rstmid_last_cnt", last_cnt, 0);
      chk("rstmid_beats", burst_beats, 2);
      exp_q.delete();
      src_q.delete();
   endtask

   task automatic test_timeout();
      int w = 0;
      int n = 0;
      grant_allow = 1'b0;
      issue(1);
      while (w < 70 && n < 200) begin
         cycle();
         n++;
         if (s_req && !s_grant) begin
            w++;
            if (w == 64) chk("timeout_before", int'(s_timeout), 0);
            if (w == 65) chk("timeout_set", int'(s_timeout), int'(TO_EN));
         end
      end
      chk("timeout_wait_cycles", w, 70);
      grant_allow = 1'b1;
      wait_idle("timeout");
      chk("timeout_beats", burst_beats, 2);
      chk("timeout_sticky", int'(o_timeout), int'(TO_EN));
      chk("timeout_burst_cnt", int'(o_burst_cnt), 1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_single();
      test_ready_toggle();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
